// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage RISC-V pipeline
//
// Resolves the hazards forwarding cannot: load-use, EX redirects, fetch wait
// states and data-memory wait states (with a timeout watchdog that parks the
// pipeline in a sticky fault state until reset).
//
// Optional feature macro: HAZ_PERF_EN (adds stall_cycles / flush_count counters).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs1, id_rs2                source registers of the ID instruction
//   id_use_rs1, id_use_rs2        ID instruction actually reads rs1 / rs2
//   id_ex_rd, id_ex_memread       destination / load flag of the EX instruction
//   ex_redirect                   EX resolved a taken branch or jump
//   imem_ready                    fetch data valid this cycle
//   dmem_req, dmem_ready          MEM-stage access and its completion
//   pc_en, pc_sel_redirect        PC update enable / select EX target
//   if_id_en, if_id_flush         IF/ID enable / bubble insert
//   id_ex_en, id_ex_flush         ID/EX enable / bubble insert
//   ex_mem_en                     EX/MEM enable
//   mem_wb_flush                  MEM/WB bubble insert
//   fault                         sticky data-memory timeout
//   stall_cycles, flush_count     (HAZ_PERF_EN) saturating event counters

module pipeline_hazard_ctrl #(
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_memread,
    input  logic       ex_redirect,
    input  logic       imem_ready,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       pc_en,
    output logic       pc_sel_redirect,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_en,
    output logic       id_ex_flush,
    output logic       ex_mem_en,
    output logic       mem_wb_flush,
    output logic       fault
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] LP_TIMEOUT = TIMEOUT_W'(MEM_TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] LP_ONE     = TIMEOUT_W'(1);

    state_t               r_state;
    state_t               w_state_next;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [TIMEOUT_W-1:0] w_cnt_next;
    logic [TIMEOUT_W-1:0] w_cnt_inc;
    logic                 w_lu;
    logic                 w_mw;

    // A load into x0 never creates a dependency.
    assign w_lu = id_ex_memread && (id_ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_ex_rd == id_rs1)) ||
                   (id_use_rs2 && (id_ex_rd == id_rs2)));
    assign w_mw      = dmem_req && !dmem_ready;
    assign w_cnt_inc = r_cnt + LP_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        pc_en           = 1'b1;
        pc_sel_redirect = 1'b0;
        if_id_en        = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_en        = 1'b1;
        id_ex_flush     = 1'b0;
        ex_mem_en       = 1'b1;
        mem_wb_flush    = 1'b0;
        fault           = 1'b0;
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;

        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
            w_state_next = RUN;
            w_cnt_next   = '0;
        end else if (r_state == FAULT) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            fault        = 1'b1;
        end else if ((r_state == MEM_WAIT) ? !dmem_ready : w_mw) begin
            // Freeze everything up to EX/MEM; MEM/WB gets bubbles meanwhile.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            if (r_state == RUN) begin
                w_cnt_next   = LP_ONE;
                w_state_next = (MEM_TIMEOUT == 1) ? FAULT : MEM_WAIT;
            end else if (w_cnt_inc == LP_TIMEOUT) begin
                w_state_next = FAULT;
            end else begin
                w_cnt_next = w_cnt_inc;
            end
        end else begin
            // RUN without a memory wait, or the release cycle of MEM_WAIT.
            w_state_next = RUN;
            w_cnt_next   = '0;
            if (ex_redirect) begin
                pc_sel_redirect = 1'b1;
                if_id_flush     = 1'b1;
                id_ex_flush     = 1'b1;
            end else if (w_lu) begin
                // Holding IF/ID also covers a simultaneous fetch wait.
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (!imem_ready) begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!pc_en && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (pc_sel_redirect && (r_flush_count != 32'hFFFF_FFFF)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl

module tb_pipeline_hazard_ctrl;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, id_ex_rd;
    logic       id_use_rs1, id_use_rs2, id_ex_memread;
    logic       ex_redirect, imem_ready, dmem_req, dmem_ready;
    logic       pc_en, pc_sel_redirect, if_id_en, if_id_flush;
    logic       id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, fault;
`ifdef HAZ_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT_W(8), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
        .ex_redirect(ex_redirect), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .pc_sel_redirect(pc_sel_redirect),
        .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .mem_wb_flush(mem_wb_flush),
        .fault(fault)
`ifdef HAZ_PERF_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    // Output vector order: pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en,
    // id_ex_flush, ex_mem_en, mem_wb_flush, fault
    logic [8:0] dut_vec;
    assign dut_vec = {pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en,
                      id_ex_flush, ex_mem_en, mem_wb_flush, fault};

    localparam logic [8:0] V_RESET = 9'b000101010;
    localparam logic [8:0] V_RUN   = 9'b101010100;
    localparam logic [8:0] V_LU    = 9'b000011100;
    localparam logic [8:0] V_REDIR = 9'b111111100;
    localparam logic [8:0] V_IMISS = 9'b001110100;
    localparam logic [8:0] V_STALL = 9'b000000010;
    localparam logic [8:0] V_FAULT = 9'b000000011;

    // Model: "waiting" tracks an outstanding data-memory access, m_n counts
    // consecutive cycles the pipeline has been frozen by it.
    bit          m_waiting = 0;
    bit          m_faulted = 0;
    int          m_n       = 0;
    longint      m_stall   = 0;
    longint      m_flush   = 0;

    function automatic bit model_frozen();
        if (m_waiting) return !dmem_ready;
        return dmem_req && !dmem_ready;
    endfunction

    function automatic logic [8:0] model_out();
        bit uses_dep;
        if (rst) return V_RESET;
        if (m_faulted) return V_FAULT;
        if (model_frozen()) return V_STALL;
        uses_dep = id_ex_memread && id_ex_rd != 0 &&
                   ((id_use_rs1 && id_ex_rd == id_rs1) || (id_use_rs2 && id_ex_rd == id_rs2));
        if (ex_redirect) return V_REDIR;
        if (uses_dep) return V_LU;
        if (!imem_ready) return V_IMISS;
        return V_RUN;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, then model advance at the edge.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            e = model_out();
            check("model_outputs", {23'd0, dut_vec}, {23'd0, e});
`ifdef HAZ_PERF_EN
            check("model_stall_cycles", stall_cycles, 32'(m_stall));
            check("model_flush_count", flush_count, 32'(m_flush));
`endif
            @(posedge clk);
            if (rst) begin
                m_waiting = 0; m_faulted = 0; m_n = 0; m_stall = 0; m_flush = 0;
            end else begin
                if (!e[8] && m_stall < 64'hFFFF_FFFF) m_stall++;
                if (e[7] && m_flush < 64'hFFFF_FFFF) m_flush++;
                if (!m_faulted) begin
                    if (model_frozen()) begin
                        m_n = m_waiting ? m_n + 1 : 1;
                        m_waiting = 1;
                        if (m_n == TMO) begin
                            m_faulted = 1;
                            m_waiting = 0;
                        end
                    end else begin
                        m_waiting = 0;
                        m_n = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_ex_memread = 0;
        ex_redirect = 0; imem_ready = 1; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic lit(input string name, input logic [8:0] exp);
        #2;
        check(name, {23'd0, dut_vec}, {23'd0, exp});
    endtask

    task automatic set_lu();
        id_ex_memread = 1; id_ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        idle();
        lit("reset_outputs", V_RESET);
        step();
        ex_redirect = 1; dmem_req = 1; imem_ready = 0;
        lit("reset_forces_outputs", V_RESET);
        step();
        rst = 0; idle();
        lit("run_default", V_RUN);

        step(); set_lu();
        lit("load_use_stall", V_LU);
        step(); id_ex_memread = 0;
        lit("load_use_released", V_RUN);

        step(); idle(); id_ex_memread = 1; id_ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        lit("x0_load_no_stall", V_RUN);
        step(); idle(); id_ex_memread = 1; id_ex_rd = 7; id_rs2 = 7; id_use_rs2 = 0;
        lit("unused_rs2_no_stall", V_RUN);
        step(); id_use_rs2 = 1;
        lit("rs2_load_use", V_LU);

        step(); idle(); set_lu(); ex_redirect = 1;
        lit("redirect_overrides_lu", V_REDIR);
        step(); ex_redirect = 0; imem_ready = 0;
        lit("lu_with_imem_wait", V_LU);
        step(); idle(); imem_ready = 0;
        lit("imem_wait", V_IMISS);
        step(); idle(); dmem_ready = 1;
        lit("dmem_ready_without_req", V_RUN);

        // Three wait cycles then release.
        step(); idle(); dmem_req = 1;
        for (int i = 0; i < 3; i++) begin
            lit("mem_wait_stall", V_STALL);
            step();
        end
        dmem_ready = 1;
        lit("mem_wait_release", V_RUN);
        step(); dmem_ready = 0;
        lit("mem_wait_again", V_STALL);
        step(); dmem_ready = 1; ex_redirect = 1; set_lu();
        lit("release_with_redirect", V_REDIR);
        step(); idle();
        lit("after_release", V_RUN);

        // Timeout: TMO frozen cycles, then sticky fault.
        step(); dmem_req = 1;
        for (int i = 0; i < TMO; i++) begin
            lit("timeout_wait", V_STALL);
            step();
        end
        lit("fault_entered", V_FAULT);
        step(); dmem_ready = 1;
        lit("fault_sticky_ready", V_FAULT);
        step(); idle();
        lit("fault_sticky_idle", V_FAULT);
        step(); rst = 1;
        lit("fault_cleared_by_rst", V_RESET);
        step(); rst = 0;
        lit("run_after_fault", V_RUN);

        // Reset during the second wait cycle.
        step(); dmem_req = 1;
        lit("midwait_first", V_STALL);
        step();
        lit("midwait_second", V_STALL);
        rst = 1; dmem_req = 0;
        #1;
        check("midwait_rst", {23'd0, dut_vec}, {23'd0, V_RESET});
        step(); rst = 0;
        lit("post_reset_run", V_RUN);
`ifdef HAZ_PERF_EN
        check("post_reset_stall_cycles", stall_cycles, 32'd0);
`endif
        step(); step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve:
- load-use dependencies
- taken branch/jump redirects from EX
- instruction-fetch wait states
- multi-cycle data-memory handshakes, with a timeout watchdog

It drives per-stage register enables and bubble-insert (flush) controls. It holds a small state machine and wait counter.

Parameters:
TIMEOUT_W, 8, width of the data-memory wait counter
MEM_TIMEOUT, 200, maximum consecutive wait cycles before fault (1..2^TIMEOUT_W-1)

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_ex_rd  in  5  rd of instruction in EX
id_ex_memread  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved taken branch/jump
imem_ready  in  1  fetch data valid this cycle
dmem_req  in  1  MEM stage issues load/store
dmem_ready  in  1  data memory completes this cycle
pc_en  out  1  PC register update enable
pc_sel_redirect  out  1  select EX target for PC
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  load bubble into IF/ID
id_ex_en  out  1  ID/EX register enable
id_ex_flush  out  1  load bubble into ID/EX
ex_mem_en  out  1  EX/MEM register enable
mem_wb_flush  out  1  load bubble into MEM/WB
fault  out  1  memory timeout, sticky

Behaviour:

States and reset
- States: RUN, MEM_WAIT, FAULT. Reset → RUN, wait counter 0, fault 0.
- While rst=1, all outputs are forced regardless of inputs:
  - all enables = 0
  - if_id_flush = 1, id_ex_flush = 1, mem_wb_flush = 1
  - pc_sel_redirect = 0, fault = 0

Default
- All outputs are combinational from state and current inputs (zero-latency).
- Default in RUN: all enables = 1, all flushes = 0, pc_sel_redirect = 0.

Hazard terms
- lu (load-use) = id_ex_memread && id_ex_rd != 0 && ((id_use_rs1 && id_ex_rd == id_rs1) || (id_use_rs2 && id_ex_rd == id_rs2)).
- mw (memory wait) = dmem_req && !dmem_ready.

RUN priority, highest first
1. mw:
   - pc_en = if_id_en = id_ex_en = ex_mem_en = 0
   - mem_wb_flush = 1
   - next state MEM_WAIT, counter = 1
   - redirect/lu are ignored this cycle. EX is frozen, so they re-evaluate after release.
2. ex_redirect:
   - pc_sel_redirect = 1, pc_en = 1
   - if_id_flush = 1, id_ex_flush = 1
   - overrides lu, because the dependent instruction is squashed.
3. lu:
   - pc_en = 0, if_id_en = 0, id_ex_flush = 1
   - exactly one bubble; the condition clears on the next cycle because the bubble has memread = 0.
4. !imem_ready:
   - pc_en = 0, if_id_flush = 1
   - later stages advance.
- lu and !imem_ready together: lu actions take effect; IF/ID is held, not flushed.

MEM_WAIT
- Outputs are the same as the mw row.
- dmem_ready = 1: release this cycle (RUN-default enables, mem_wb_flush = 0), next state RUN, counter = 0. Redirect, lu and !imem_ready in that same cycle apply using the RUN priority rules (rows 2–4).
- Otherwise the counter increments. If the counter == MEM_TIMEOUT while dmem_ready = 0, next state is FAULT.
- The counter never wraps; this is guaranteed by the MEM_TIMEOUT range.

FAULT
- fault = 1.
- All enables = 0, mem_wb_flush = 1; if_id_flush = id_ex_flush = 0.
- Exited only by rst.

Other rules
- rst asserted mid-wait: next cycle is RUN with counter 0, with no residual stall.
- dmem_ready with dmem_req = 0 is ignored in RUN.

Optional Feature:
Macro HAZ_PERF_EN.
- Defined:
  - Extra ports: stall_cycles out 32, flush_count out 32.
  - stall_cycles increments in every non-reset cycle where pc_en = 0.
  - flush_count increments once per cycle with ex_redirect honored (pc_sel_redirect = 1).
  - Both counters are cleared by rst and saturate at 0xFFFFFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rd=5, id_rs1=5, id_use_rs1=1 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; next cycle (memread=0) all enables 1.
- x0 load: same as above with id_ex_rd=0, id_rs1=0 → no stall; also id_use_rs2=0 with rd=rs2=7 → no stall.
- Redirect+lu: ex_redirect=1 and lu both true → pc_sel_redirect=1, pc_en=1, if_id_flush=1, id_ex_flush=1, if_id_en=1.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 → 3 cycles all enables 0, mem_wb_flush=1; release cycle enables 1, state RUN, counter 0.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 → FAULT entered after 4th wait cycle, fault=1 sticky with later dmem_ready=1; rst for 1 cycle → fault=0, RUN.
- Reset mid-wait: rst pulsed during cycle 2 of MEM_WAIT with dmem_req=0 afterward → post-reset all enables 1, no flush; with HAZ_PERF_EN, stall_cycles=0 after reset.
